gravador_sequencia: RTL and testbench
=====================================

// Module: gravador_sequencia
// PURPOSE
//   Writer side of the memory-sequence game: records the key sequence the player enters
//   into an internal 16x4 synchronous RAM, one entry per key press.
//   Provides a synchronous read port so the game datapath can replay or compare the
//   stored sequence, plus the recorded length.
// PARAMETERS
//   DATA_W  4   width of chaves and of each stored entry
//   ADDR_W  4   RAM address width
//   DEPTH   16  RAM entries (= 2**ADDR_W); maximum recordable length
// PORTS
//   clock        in   1         rising-edge clock
//   reset_n      in   1         asynchronous, active-low reset
//   iniciar      in   1         start recording (sampled in IDLE and FIM only)
//   parar        in   1         end recording (sampled in ESPERA only)
//   chaves       in   DATA_W    player keys, one-hot when valid
//   rd_endereco  in   ADDR_W    read address
//   rd_dado      out  DATA_W    registered read data, 1-cycle latency
//   tamanho      out  ADDR_W+1  number of entries written (0..DEPTH)
//   gravando     out  1         high in ESPERA, GRAVA, SOLTA
//   pronto       out  1         high in FIM
//   db_erro      out  1         1-cycle pulse: non-zero, non-one-hot chaves seen in ESPERA
//   db_estado    out  3         state code
// BEHAVIOUR
// - reset_n=0: state IDLE; tamanho, rd_dado, db_erro = 0; RAM contents not cleared.
// - States/codes: IDLE=0, ESPERA=1, GRAVA=2, SOLTA=3, FIM=4; other codes -> IDLE.
// - IDLE: iniciar=1 -> ESPERA; tamanho cleared to 0.
// - ESPERA:
//   - parar=1 -> FIM. parar has priority over a same-cycle key; the key is not recorded.
//   - else one-hot chaves -> capture chaves into internal register; -> GRAVA.
//   - else chaves non-zero, not one-hot -> db_erro pulses for that cycle; stay in ESPERA.
//   - chaves=0 -> stay.
// - GRAVA (exactly 1 cycle):
//   - mem[tamanho[ADDR_W-1:0]] <= captured key; tamanho <= tamanho+1; -> SOLTA.
// - SOLTA: wait for chaves==0.
//   - Then tamanho==DEPTH -> FIM; else -> ESPERA.
//   - A held key is recorded once, regardless of hold time.
// - FIM: pronto=1; tamanho held.
//   - iniciar=1 -> ESPERA with tamanho cleared; previous RAM data is overwritten as recording proceeds.
// - iniciar is ignored in ESPERA/GRAVA/SOLTA. parar is ignored outside ESPERA.
// - No wrap-around: tamanho saturates at DEPTH; RAM is never written with tamanho==DEPTH.
// - Read port: rd_dado <= mem[rd_endereco] every cycle, independent of state.
//   - Read of an address written in the same cycle returns the old data.
// - Latency: key seen in ESPERA at edge n; RAM write and tamanho increment at edge n+1;
//   data readable at edge n+2 (rd_dado valid after n+2).
// - Reset asserted mid-operation (any state) -> immediate IDLE; a partial write never corrupts other entries.
// TESTING
// - Record 3 entries:
//   - Stimulus: iniciar; keys 0001, 0100, 1000, each followed by release; then parar.
//   - Response: tamanho=3, pronto=1; rd_endereco 0/1/2 -> rd_dado 0001/0100/1000 one cycle later.
// - Fill to capacity:
//   - Stimulus: 16 press/release cycles of 0010, no parar.
//   - Response: after the 16th release, state FIM, tamanho=16, pronto=1; a 17th press causes no write.
// - Invalid key:
//   - Stimulus: chaves=0110 in ESPERA.
//   - Response: db_erro=1 for 1 cycle, tamanho unchanged, stays ESPERA; then 0100 records normally.
// - Long hold and priority:
//   - Stimulus: hold 1000 for 20 cycles.
//   - Response: tamanho increments by exactly 1.
//   - Stimulus: parar and 0001 in the same ESPERA cycle.
//   - Response: FIM, no write.
// - Reset mid-record:
//   - Stimulus: pull reset_n low in GRAVA after 2 entries.
//   - Response: IDLE, tamanho=0, outputs 0; entries 0-1 still readable with their values.
// - Restart:
//   - Stimulus: from FIM with tamanho=3, iniciar then one key 0001.
//   - Response: tamanho=1, mem[0]=0001, mem[1..2] unchanged.

Source files
------------

// File: rtl/gravador_sequencia.sv
// ---------------------------------------------------------------------------
// gravador_sequencia
//   Writer side of the memory-sequence game. Each key press the player makes
//   while recording is stored as one entry of an internal DEPTH x DATA_W
//   synchronous RAM. A free-running synchronous read port lets the game
//   datapath replay or compare the stored sequence.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous, active-low reset
//   iniciar      start recording (honoured in IDLE and FIM)
//   parar        end recording (honoured in ESPERA)
//   chaves       player keys, one-hot when valid
//   rd_endereco  read address
//   rd_dado      registered read data, 1-cycle latency
//   tamanho      number of entries written (0..DEPTH)
//   gravando     high while recording (ESPERA, GRAVA, SOLTA)
//   pronto       high in FIM
//   db_erro      high in an ESPERA cycle showing a non-zero, non-one-hot key
//   db_estado    current state code
// ---------------------------------------------------------------------------
module gravador_sequencia #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [DATA_W-1:0] chaves,
    input  logic [ADDR_W-1:0] rd_endereco,
    output logic [DATA_W-1:0] rd_dado,
    output logic [ADDR_W:0]   tamanho,
    output logic              gravando,
    output logic              pronto,
    output logic              db_erro,
    output logic [2:0]        db_estado
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ESPERA = 3'd1;
    localparam logic [2:0] GRAVA  = 3'd2;
    localparam logic [2:0] SOLTA  = 3'd3;
    localparam logic [2:0] FIM    = 3'd4;

    localparam logic [ADDR_W:0] CHEIO = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] UM    = (ADDR_W+1)'(1);

    logic [2:0]        estado;
    logic [2:0]        prox;
    logic [DATA_W-1:0] chave_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic tecla_valida;
    logic tecla_invalida;
    logic tecla_solta;
    logic captura;
    logic reinicia;
    logic wr_en;

    assign tecla_valida   = $onehot(chaves);
    assign tecla_solta    = (chaves == '0);
    assign tecla_invalida = !tecla_solta && !tecla_valida;

    // parar wins over a key seen in the same ESPERA cycle
    assign captura  = (estado == ESPERA) && !parar && tecla_valida;
    assign reinicia = ((estado == IDLE) || (estado == FIM)) && iniciar;

    // The full check is redundant with the SOLTA exit, but keeps the RAM
    // from ever being addressed by a wrapped count.
    assign wr_en = (estado == GRAVA) && (tamanho != CHEIO);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        prox = estado;
        case (estado)
            IDLE: begin
                if (iniciar) prox = ESPERA;
            end
            ESPERA: begin
                if (parar)             prox = FIM;
                else if (tecla_valida) prox = GRAVA;
            end
            GRAVA: begin
                prox = SOLTA;
            end
            SOLTA: begin
                // A held key is recorded once: only leave after release.
                if (tecla_solta) prox = (tamanho == CHEIO) ? FIM : ESPERA;
            end
            FIM: begin
                if (iniciar) prox = ESPERA;
            end
            default: begin
                prox = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, length counter and captured key
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= IDLE;
            tamanho   <= '0;
            chave_reg <= '0;
        end else begin
            estado <= prox;
            if (reinicia)   tamanho <= '0;
            else if (wr_en) tamanho <= tamanho + UM;
            if (captura) chave_reg <= chaves;
        end
    end

    // -----------------------------------------------------------------------
    // RAM: no reset on the array so contents survive reset_n. The async reset
    // forces the FSM out of GRAVA, so a write interrupted by reset is dropped
    // rather than landing at some other address.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) mem[tamanho[ADDR_W-1:0]] <= chave_reg;
    end

    // Read-before-write: a same-cycle read of the written entry sees old data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_dado <= '0;
        else          rd_dado <= mem[rd_endereco];
    end

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    assign gravando  = (estado == ESPERA) || (estado == GRAVA) || (estado == SOLTA);
    assign pronto    = (estado == FIM);
    assign db_erro   = (estado == ESPERA) && !parar && tecla_invalida;
    assign db_estado = estado;

endmodule

// File: tb/tb_gravador_sequencia.sv
// Bench for gravador_sequencia: directed scenarios followed by random
// press/stop/start traffic, checked against a transaction-level model
// (recorded list + length + recording/done flags).
module tb_gravador_sequencia;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       iniciar;
    logic       parar;
    logic [3:0] chaves;
    logic [3:0] rd_endereco;
    logic [3:0] rd_dado;
    logic [4:0] tamanho;
    logic       gravando;
    logic       pronto;
    logic       db_erro;
    logic [2:0] db_estado;

    gravador_sequencia dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .iniciar     (iniciar),
        .parar       (parar),
        .chaves      (chaves),
        .rd_endereco (rd_endereco),
        .rd_dado     (rd_dado),
        .tamanho     (tamanho),
        .gravando    (gravando),
        .pronto      (pronto),
        .db_erro     (db_erro),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // reference model
    bit         recording = 0;
    bit         done      = 0;
    int         len       = 0;
    logic [3:0] mem_m [16];
    bit         wv    [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_status();
        @(negedge clock);
        chk("estado",   db_estado, recording ? 3'd1 : (done ? 3'd4 : 3'd0));
        chk("gravando", gravando,  recording);
        chk("pronto",   pronto,    done);
        chk("tamanho",  tamanho,   len);
        chk("db_erro",  db_erro,   1'b0);
        cyc();
    endtask

    task automatic start();
        iniciar = 1'b1;
        cyc();
        iniciar = 1'b0;
        if (!recording) begin
            recording = 1;
            done      = 0;
            len       = 0;
        end
        check_status();
    endtask

    task automatic stop(input logic [3:0] k);
        parar  = 1'b1;
        chaves = k;
        @(negedge clock);
        chk("erro_parar", db_erro, 1'b0);
        cyc();
        parar  = 1'b0;
        chaves = '0;
        cyc();
        if (recording) begin
            recording = 0;
            done      = 1;
        end
        check_status();
    endtask

    // Press k for 'hold' cycles then release; optionally wiggle iniciar
    // while the key is held (must be ignored).
    task automatic press(input logic [3:0] k, input int hold, input bit stray);
        bit         rec  = recording;
        bit         ok   = recording && $onehot(k);
        logic [3:0] a    = len[3:0];
        int         last = ((hold > 2) ? hold : 2) + 2;
        for (int c = 0; c < last; c++) begin
            chaves  = (c < hold) ? k : 4'd0;
            iniciar = stray && rec && (c >= 1) && (c < hold);
            if (c == 1) rd_endereco = a;
            @(negedge clock);
            if (c == 0) chk("db_erro_key", db_erro, rec && (k != 4'd0) && !$onehot(k));
            if (ok && c == 2) begin
                if (wv[a]) chk("rd_old", rd_dado, mem_m[a]);
                chk("tam_inc", tamanho, len + 1);
            end
            if (ok && c == 3) chk("rd_new", rd_dado, k);
            cyc();
        end
        iniciar = 1'b0;
        chaves  = '0;
        if (ok) begin
            mem_m[a] = k;
            wv[a]    = 1;
            len++;
            if (len == 16) begin
                recording = 0;
                done      = 1;
            end
        end
        check_status();
    endtask

    task automatic dump();
        for (int a = 0; a < 16; a++) begin
            if (wv[a]) begin
                rd_endereco = 4'(a);
                cyc();
                chk($sformatf("mem[%0d]", a), rd_dado, mem_m[a]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] k;
        int         op;
        for (int i = 0; i < 16; i++) wv[i] = 0;
        reset_n     = 1'b0;
        iniciar     = 1'b0;
        parar       = 1'b0;
        chaves      = '0;
        rd_endereco = '0;
        cyc();
        cyc();
        // reset state
        chk("rst_estado",  db_estado, 3'd0);
        chk("rst_tamanho", tamanho,   5'd0);
        chk("rst_rd_dado", rd_dado,   4'd0);
        chk("rst_erro",    db_erro,   1'b0);
        chk("rst_grav",    gravando,  1'b0);
        chk("rst_pronto",  pronto,    1'b0);
        reset_n = 1'b1;
        cyc();
        check_status();

        // record three entries
        start();
        press(4'b0001, 1, 0);
        press(4'b0100, 2, 0);
        press(4'b1000, 3, 0);
        stop(4'b0000);
        dump();

        // restart from FIM with three entries
        start();
        press(4'b0001, 2, 1);
        stop(4'b0000);
        dump();

        // invalid key, then a normal one
        start();
        press(4'b0110, 1, 0);
        press(4'b0100, 1, 0);
        // long hold counts once; parar beats a same-cycle key
        press(4'b1000, 20, 1);
        stop(4'b0001);
        dump();

        // reset while in GRAVA after two entries
        start();
        press(4'b0010, 1, 0);
        press(4'b0001, 2, 0);
        chaves = 4'b0100;
        cyc();
        chk("pre_rst_grava", db_estado, 3'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_estado",  db_estado, 3'd0);
        chk("mid_rst_tamanho", tamanho,   5'd0);
        chk("mid_rst_rd",      rd_dado,   4'd0);
        chk("mid_rst_pronto",  pronto,    1'b0);
        cyc();
        reset_n = 1'b1;
        chaves  = '0;
        recording = 0;
        done      = 0;
        len       = 0;
        check_status();
        dump();

        // fill to capacity; a 17th press is ignored
        start();
        for (int i = 0; i < 16; i++) press(4'b0010, $urandom_range(1, 3), 0);
        press(4'b0001, 2, 0);
        stop(4'b0000);
        dump();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: start();
                1: begin
                    k = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
                    stop(k);
                end
                2: begin
                    do k = 4'($urandom_range(1, 15)); while ($onehot(k));
                    press(k, 1, 0);
                end
                3: begin
                    cyc();
                    check_status();
                end
                default: begin
                    k = 4'b0001 << $urandom_range(0, 3);
                    press(k, $urandom_range(1, 5), 1'($urandom_range(0, 1)));
                end
            endcase
            if (n % 50 == 49) dump();
        end
        dump();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
